// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register slave: frame layout, register
// addresses and the frame FSM state type.
package spi_reg_pkg;

  localparam int FRAME_BITS = 16;
  localparam int RW_BIT     = 15;
  localparam int ADDR_MSB   = 14;
  localparam int ADDR_LSB   = 8;
  localparam int REG_COUNT  = 5;

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_PWM_DUTY  = 7'h04;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } frame_state_e;

endpackage

// File: rtl/sync_edge.sv
// Multi-stage synchronizer for one asynchronous pin, followed by a history
// flop that turns the synchronized level into single-cycle edge strobes.
module sync_edge #(
  parameter int   STAGES     = 2,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              hist_q;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbour; blocking here would
  // collapse the synchronizer chain into a single stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{IDLE_LEVEL}};
      hist_q <= IDLE_LEVEL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], pin};
      hist_q <= sync_q[STAGES-1];
    end
  end

  assign level = sync_q[STAGES-1];
  assign rise  = level & ~hist_q;
  assign fall  = ~level & hist_q;

endmodule

// File: rtl/spi_reg_slave.sv
// SPI mode-0 write-only slave: receives {rw, addr, data} frames and commits
// them into the PWM control registers when nCS rises.
module spi_reg_slave
  import spi_reg_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_REGS    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_pulse
);

  logic sclk_level, sclk_rise, sclk_fall;
  logic copi_level, copi_rise, copi_fall;
  logic ncs_level,  ncs_rise,  ncs_fall;

  sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .pin(sclk),
    .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b0)) u_sync_copi (
    .clk(clk), .rst(rst), .pin(copi),
    .level(copi_level), .rise(copi_rise), .fall(copi_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .IDLE_LEVEL(1'b1)) u_sync_ncs (
    .clk(clk), .rst(rst), .pin(ncs),
    .level(ncs_level), .rise(ncs_rise), .fall(ncs_fall)
  );

  // Mode 0 samples on SCLK rise only; the remaining strobes are intentionally idle.
  logic unused_edges;
  assign unused_edges = ^{sclk_level, sclk_fall, copi_rise, copi_fall};

  frame_state_e          state_q, state_d;
  logic [FRAME_BITS-1:0] shift_q;
  logic [4:0]            bit_cnt_q;
  logic [7:0]            regs_q [REG_COUNT];
  logic                  wr_pulse_q;

  logic       start, shift_en, commit, frame_ok;
  logic [6:0] frame_addr;
  logic [7:0] frame_data;

  assign frame_addr = shift_q[ADDR_MSB:ADDR_LSB];
  assign frame_data = shift_q[7:0];
  assign frame_ok   = (bit_cnt_q == 5'(FRAME_BITS)) && shift_q[RW_BIT] &&
                      (frame_addr < 7'(NUM_REGS));

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    start    = 1'b0;
    shift_en = 1'b0;
    commit   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ncs_fall) begin
          state_d = ST_RECV;
          start   = 1'b1;
        end
      end
      ST_RECV: begin
        // A coincident SCLK rise is dropped so the commit sees the pre-shift frame.
        if (ncs_rise) begin
          state_d = ST_IDLE;
          commit  = frame_ok;
        end else if (sclk_rise && !ncs_level) begin
          shift_en = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else if (start) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else if (shift_en) begin
      shift_q <= {shift_q[FRAME_BITS-2:0], copi_level};
      if (bit_cnt_q != 5'd31) bit_cnt_q <= bit_cnt_q + 5'd1;
    end
  end

  // NOTE: the register file is only five bytes and drives the PWM block
  // directly, so it is reset; a large RAM-style array would not be.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_COUNT; i++) regs_q[i] <= 8'h00;
      wr_pulse_q <= 1'b0;
    end else begin
      wr_pulse_q <= commit;
      for (int i = 0; i < REG_COUNT; i++) begin
        if (commit && frame_addr == 7'(i)) regs_q[i] <= frame_data;
      end
    end
  end

  assign en_reg_out_7_0  = regs_q[ADDR_EN_OUT_LO];
  assign en_reg_out_15_8 = regs_q[ADDR_EN_OUT_HI];
  assign en_reg_pwm_7_0  = regs_q[ADDR_EN_PWM_LO];
  assign en_reg_pwm_15_8 = regs_q[ADDR_EN_PWM_HI];
  assign pwm_duty_cycle  = regs_q[ADDR_PWM_DUTY];
  assign wr_pulse        = wr_pulse_q;

endmodule

// File: tb/tb_spi_reg_slave.sv
// Directed self-checking bench for spi_reg_slave: bit-banged SPI frames at
// SCLK = clk/8 with hand-computed register expectations.
module tb_spi_reg_slave;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sclk = 1'b0;
  logic       copi = 1'b0;
  logic       ncs = 1'b1;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
  logic       wr_pulse;

  spi_reg_slave dut (
    .clk(clk), .rst(rst), .sclk(sclk), .copi(copi), .ncs(ncs),
    .en_reg_out_7_0(en_reg_out_7_0), .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0(en_reg_pwm_7_0), .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle), .wr_pulse(wr_pulse)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rise_cyc = 0;
  int pulse_cnt = 0;
  int max_lat = 0;
  logic [39:0] snaps [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: counts strobes, tracks latency from the nCS pin rise and
  // snapshots the register file at every strobe for ordering checks.
  always @(negedge clk) begin
    if (wr_pulse) begin
      pulse_cnt = pulse_cnt + 1;
      if (cyc - rise_cyc > max_lat) max_lat = cyc - rise_cyc;
      snaps.push_back({pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0,
                       en_reg_out_15_8, en_reg_out_7_0});
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic shift_bits(input logic [31:0] word, input int n, input bit close_on_last);
    for (int i = n - 1; i >= 0; i--) begin
      copi = word[i];
      wait_clk(4);
      sclk = 1'b1;
      if (i == 0 && close_on_last) begin
        ncs = 1'b0 ^ 1'b1;
        rise_cyc = cyc;
      end
      wait_clk(4);
      sclk = 1'b0;
    end
  endtask

  task automatic frame(input logic [31:0] word, input int n, input int gap, input bit close_on_last);
    ncs = 1'b0;
    wait_clk(4);
    shift_bits(word, n, close_on_last);
    if (!close_on_last) begin
      wait_clk(4);
      ncs = 1'b1;
      rise_cyc = cyc;
    end
    wait_clk(gap);
  endtask

  task automatic check_regs(input string tag, input logic [39:0] exp, input int exp_pulses);
    check({tag, "_r0"}, en_reg_out_7_0,  exp[7:0]);
    check({tag, "_r1"}, en_reg_out_15_8, exp[15:8]);
    check({tag, "_r2"}, en_reg_pwm_7_0,  exp[23:16]);
    check({tag, "_r3"}, en_reg_pwm_15_8, exp[31:24]);
    check({tag, "_r4"}, pwm_duty_cycle,  exp[39:32]);
    check({tag, "_pulses"}, pulse_cnt, exp_pulses);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with random pin activity beforehand.
    sclk = 1'($urandom_range(1));
    copi = 1'($urandom_range(1));
    ncs  = 1'($urandom_range(1));
    wait_clk(3);
    sclk = 1'b0; copi = 1'b0; ncs = 1'b1;
    rst = 1'b1;
    wait_clk(2);
    rst = 1'b0;
    wait_clk(4);
    check_regs("reset", 40'h00_00_00_00_00, 0);
    check("reset_wr_pulse", wr_pulse, 1'b0);

    // Two plain writes.
    frame(32'h80FF, 16, 8, 1'b0);
    check_regs("wr_80ff", 40'h00_00_00_00_FF, 1);
    frame(32'h8455, 16, 8, 1'b0);
    check_regs("wr_8455", 40'h55_00_00_00_FF, 2);
    check("wr_latency_le3", (max_lat <= 3 && max_lat >= 1), 1'b1);

    // Dropped frames.
    frame(32'h0312, 16, 8, 1'b0);
    check_regs("drop_read", 40'h55_00_00_00_FF, 2);
    frame(32'h85AA, 16, 8, 1'b0);
    check_regs("drop_badaddr", 40'h55_00_00_00_FF, 2);
    frame(32'h4008, 15, 8, 1'b0);
    check_regs("drop_15bit", 40'h55_00_00_00_FF, 2);
    frame(32'h1_8122, 17, 8, 1'b0);
    check_regs("drop_17bit", 40'h55_00_00_00_FF, 2);

    // Back-to-back writes with a 3-clk nCS gap.
    frame(32'h81A5, 16, 3, 1'b0);
    frame(32'h833C, 16, 8, 1'b0);
    check_regs("b2b", 40'h55_3C_00_A5_FF, 4);
    check("b2b_first_snap",  snaps[2], 40'h55_00_00_A5_FF);
    check("b2b_second_snap", snaps[3], 40'h55_3C_00_A5_FF);

    // Reset mid-frame, then a clean frame.
    ncs = 1'b0;
    wait_clk(4);
    shift_bits(32'h84, 8, 1'b0);
    rst = 1'b1;
    wait_clk(2);
    rst = 1'b0;
    wait_clk(2);
    ncs = 1'b1;
    wait_clk(6);
    check_regs("midreset", 40'h00_00_00_00_00, 4);
    frame(32'h82C3, 16, 8, 1'b0);
    check_regs("after_midreset", 40'h00_00_C3_00_00, 5);

    // nCS rise coincides with the 16th SCLK rise: only 15 bits count.
    frame(32'h8477, 16, 8, 1'b1);
    check_regs("ncs_with_sclk16", 40'h00_00_C3_00_00, 5);
    check("final_wr_pulse", wr_pulse, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
